// File: rtl/traffic_pkg.sv
// Shared constants for the traffic controller and its per-lane car counters.
package traffic_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned CAR_CNT_W = 4;

  localparam int unsigned LANE_NS = 0;
  localparam int unsigned LANE_SN = 1;
  localparam int unsigned LANE_EW = 2;
  localparam int unsigned LANE_WE = 3;

  localparam int unsigned DEBOUNCE_DEFAULT = 16;

  typedef logic [CAR_CNT_W-1:0] car_cnt_t;

endpackage

// File: rtl/lane_debouncer.sv
// One lane: polarity normalisation, two-flop synchroniser, debounce counter and
// accepted level. Emits a one-cycle arrival pulse, combinational from flops only,
// that is high in the cycle the accepted level is about to flip 0 -> 1.
module lane_debouncer
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = DEBOUNCE_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sens,
  output logic arrival
);

  localparam int unsigned DW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DcntMax = DW'(DEBOUNCE - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // Synchroniser, debounce counter and accepted level; all clear to inactive.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      s1_q     <= sens ^ ACTIVE_LOW;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE cycles in a row.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    if (s2_q == stable_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DcntMax) begin
      stable_d = s2_q;
      dcnt_d   = '0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  // Arrival is the 0 -> 1 acceptance; departures are debounced but not reported.
  always_comb begin
    arrival = ~stable_q & stable_d;
  end

endmodule

// File: rtl/lane_car_counter.sv
// Four debounced vehicle sensors feeding free-running, wrapping 4-bit car counts.
// Optional feature macro: LANE_CAR_COUNTER_TOTAL_EN adds total_8b, the mod-256
// sum of arrivals over all lanes.
module lane_car_counter
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = DEBOUNCE_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sens_ns,
  input  logic       sens_sn,
  input  logic       sens_ew,
  input  logic       sens_we,
  output logic [3:0] count_ns_4b,
  output logic [3:0] count_sn_4b,
  output logic [3:0] count_ew_4b,
`ifdef LANE_CAR_COUNTER_TOTAL_EN
  output logic [3:0] count_we_4b,
  output logic [7:0] total_8b
`else
  output logic [3:0] count_we_4b
`endif
);

  logic [NUM_LANES-1:0] sens_vec;
  logic [NUM_LANES-1:0] arrival;
  car_cnt_t             count_q [NUM_LANES];

  assign sens_vec[LANE_NS] = sens_ns;
  assign sens_vec[LANE_SN] = sens_sn;
  assign sens_vec[LANE_EW] = sens_ew;
  assign sens_vec[LANE_WE] = sens_we;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_debouncer #(
      .DEBOUNCE  (DEBOUNCE),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .sens   (sens_vec[l]),
      .arrival(arrival[l])
    );
  end

  // Per-lane counts wrap mod 16 and are only ever cleared by reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (reset) begin
        count_q[l] <= '0;
      end else if (arrival[l]) begin
        count_q[l] <= count_q[l] + CAR_CNT_W'(1);
      end
    end
  end

  assign count_ns_4b = count_q[LANE_NS];
  assign count_sn_4b = count_q[LANE_SN];
  assign count_ew_4b = count_q[LANE_EW];
  assign count_we_4b = count_q[LANE_WE];

`ifdef LANE_CAR_COUNTER_TOTAL_EN
  logic [2:0] arr_sum;
  logic [7:0] total_q;

  // Number of lanes accepting an arrival this cycle (0..4).
  always_comb begin
    arr_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      arr_sum = arr_sum + {2'b00, arrival[l]};
    end
  end

  // Grand total across lanes, wrapping mod 256.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_q + {5'b00000, arr_sum};
    end
  end

  assign total_8b = total_q;
`endif

endmodule

// File: tb/tb_lane_car_counter.sv
// Directed bench for lane_car_counter (DEBOUNCE=4, ACTIVE_LOW=1) with a
// window-based reference model and per-cycle comparison.
module tb_lane_car_counter;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sens_ns = 1'b1, sens_sn = 1'b1, sens_ew = 1'b1, sens_we = 1'b1;
  logic [3:0] count_ns_4b, count_sn_4b, count_ew_4b, count_we_4b;
`ifdef LANE_CAR_COUNTER_TOTAL_EN
  logic [7:0] total_8b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  always #5 clk = ~clk;

  lane_car_counter #(
    .DEBOUNCE  (D),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sens_ns    (sens_ns),
    .sens_sn    (sens_sn),
    .sens_ew    (sens_ew),
    .sens_we    (sens_we),
    .count_ns_4b(count_ns_4b),
    .count_sn_4b(count_sn_4b),
    .count_ew_4b(count_ew_4b),
`ifdef LANE_CAR_COUNTER_TOTAL_EN
    .count_we_4b(count_we_4b),
    .total_8b   (total_8b)
`else
    .count_we_4b(count_we_4b)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a lane's accepted level flips at an edge when the DEBOUNCE
  // raw samples taken 2..DEBOUNCE+1 edges earlier all disagree with it.
  bit       hist [4][0:D];
  bit       acc  [4];
  int       mcnt [4];
  int       mtot;

  initial begin
    for (int l = 0; l < 4; l++) begin
      acc[l]  = 0;
      mcnt[l] = 0;
      for (int j = 0; j <= D; j++) hist[l][j] = 0;
    end
    mtot = 0;
  end

  always @(posedge clk) begin
    bit a [4];
    bit all_diff;
    a[0] = ~sens_ns; a[1] = ~sens_sn; a[2] = ~sens_ew; a[3] = ~sens_we;
    for (int l = 0; l < 4; l++) begin
      if (reset) begin
        acc[l]  = 0;
        mcnt[l] = 0;
        for (int j = 0; j <= D; j++) hist[l][j] = 0;
      end else begin
        all_diff = 1;
        for (int j = 1; j <= D; j++) if (hist[l][j] == acc[l]) all_diff = 0;
        if (all_diff) begin
          acc[l] = ~acc[l];
          if (acc[l]) begin
            mcnt[l] = (mcnt[l] + 1) % 16;
            mtot    = (mtot + 1) % 256;
          end
        end
        for (int j = D; j >= 1; j--) hist[l][j] = hist[l][j-1];
        hist[l][0] = a[l];
      end
    end
    if (reset) mtot = 0;
  end

  // Compare every cycle once the first reset has been applied.
  always @(negedge clk) begin
    if (started) begin
      chk("model_ns", int'(count_ns_4b), mcnt[0]);
      chk("model_sn", int'(count_sn_4b), mcnt[1]);
      chk("model_ew", int'(count_ew_4b), mcnt[2]);
      chk("model_we", int'(count_we_4b), mcnt[3]);
`ifdef LANE_CAR_COUNTER_TOTAL_EN
      chk("model_total", int'(total_8b), mtot);
`endif
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string name, input int ns, input int sn, input int ew,
                         input int we);
    chk({name, "_ns"}, int'(count_ns_4b), ns);
    chk({name, "_sn"}, int'(count_sn_4b), sn);
    chk({name, "_ew"}, int'(count_ew_4b), ew);
    chk({name, "_we"}, int'(count_we_4b), we);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with sensors inactive, then idle.
    @(posedge clk); #1;
    reset = 1'b1;
    step(1);
    reset   = 1'b0;
    started = 1;
    chk_all("reset", 0, 0, 0, 0);
`ifdef LANE_CAR_COUNTER_TOTAL_EN
    chk("reset_total", int'(total_8b), 0);
`endif
    step(100);
    chk_all("idle", 0, 0, 0, 0);

    // North-south press: visible exactly after edge 6.
    sens_ns = 1'b0;
    step(5);
    chk("ns_edge5", int'(count_ns_4b), 0);
    step(1);
    chk("ns_edge6", int'(count_ns_4b), 1);
    step(4);
    sens_ns = 1'b1;
    step(20);
    chk_all("ns_release", 1, 0, 0, 0);

    // Short east-west glitches are rejected; a 4-cycle press is accepted.
    for (int r = 0; r < 5; r++) begin
      sens_ew = 1'b0; step(3);
      sens_ew = 1'b1; step(5);
    end
    step(10);
    chk("ew_glitch", int'(count_ew_4b), 0);
    sens_ew = 1'b0; step(4);
    sens_ew = 1'b1; step(10);
    chk("ew_pulse4", int'(count_ew_4b), 1);

    // 17 clean west-east presses: 1..15, 0, 1.
    for (int p = 1; p <= 17; p++) begin
      sens_we = 1'b0; step(6);
      sens_we = 1'b1; step(6);
      chk("we_wrap", int'(count_we_4b), p % 16);
    end

    // All four lanes pressed together.
    sens_ns = 1'b0; sens_sn = 1'b0; sens_ew = 1'b0; sens_we = 1'b0;
    step(5);
    chk_all("all_edge5", 1, 0, 1, 1);
`ifdef LANE_CAR_COUNTER_TOTAL_EN
    chk("all_total5", int'(total_8b), 19);
`endif
    step(1);
    chk_all("all_edge6", 2, 1, 2, 2);
`ifdef LANE_CAR_COUNTER_TOTAL_EN
    chk("all_total6", int'(total_8b), 23);
`endif
    sens_ns = 1'b1; sens_sn = 1'b1; sens_ew = 1'b1; sens_we = 1'b1;
    step(12);

    // South-north held through a reset that lands with dcnt=2.
    sens_sn = 1'b0;
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_all("mid_reset", 0, 0, 0, 0);
    step(5);
    chk("sn_after5", int'(count_sn_4b), 0);
    step(1);
    chk("sn_after6", int'(count_sn_4b), 1);
    sens_sn = 1'b1;
    step(10);
    chk_all("final", 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
